// File: rtl/bit_index_enumerator_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_index_enumerator_if
//  Description : Valid/ready bundle for the bit index enumerator. It carries
//                the input word channel, the output index-beat channel and
//                the busy status.
//                The producer/consumer side uses the master modport.
//                The enumerator itself uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface bit_index_enumerator_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(WIDTH)
);

  // input word channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  // output beat channel
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_index;
  logic             out_last;
  logic             out_empty;
  logic [IDXW:0]    out_seq;

  // status
  logic             busy;

  // Producer and consumer side of the enumerator.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_last,
    input  out_empty,
    input  out_seq,
    input  busy
  );

  // The enumerator's own view of the bundle.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_last,
    output out_empty,
    output out_seq,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/bit_index_enumerator.sv
`default_nettype none
// ============================================================================
//  Module      : bit_index_enumerator
//  Description : Streaming decoder. It takes in one WIDTH-bit word and
//                emits the positions of its set bits, highest position
//                first, one index per output beat. A word with no set bits
//                produces a single beat with out_empty set.
//
//                Integration note: in_ready is not registered. It depends
//                combinationally on out_ready, so the next word can be
//                accepted on the same cycle as the last beat's handshake.
//                The output channel has no combinational path from any
//                input. out_valid comes from a register. out_index and
//                out_last are decoded from the registered residual word.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_index_enumerator #(
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bit_index_enumerator_if.slave   bus
);

  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
  localparam logic [IDXW:0]    c_seq_one  = (IDXW+1)'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_residual;   // set bits not yet emitted
  logic [IDXW:0]    r_seq;        // ordinal of the current beat
  logic             r_valid;
  logic             r_busy;
  logic             r_empty;      // the held word was all zeros

  logic [IDXW-1:0]  w_index;
  logic             w_onehot;
  logic             w_last;
  logic             w_out_fire;
  logic             w_in_ready;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_clear_mask;

  // Priority encoder: the highest set bit of the residual wins, because
  // later loop iterations override earlier ones.
  always_comb begin
    w_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_residual[i]) begin
        w_index = IDXW'(i);
      end
    end
  end

  // Beat decode and handshake qualifiers. The last beat is either the
  // single beat of an empty word or the beat that holds the only
  // remaining set bit.
  always_comb begin
    w_onehot     = (r_residual != '0) &&
                   ((r_residual & (r_residual - c_one)) == '0);
    w_last       = r_valid && (r_empty || w_onehot);
    w_clear_mask = ~(c_one << w_index);
    w_out_fire   = r_valid && bus.out_ready;
    w_in_ready   = rst_n &&
                   ((r_state == S_IDLE) || (w_out_fire && w_last));
    w_in_fire    = bus.in_valid && w_in_ready;
  end

  // Control FSM with registered valid/busy/empty flags. When a last-beat
  // handshake and an input accept happen in the same cycle, the accept
  // wins. This keeps the block in EMIT with no idle bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_residual <= '0;
      r_seq      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_empty    <= 1'b0;
    end else begin
      if (w_out_fire) begin
        r_residual <= r_residual & w_clear_mask;
        if (w_last) begin
          // Return the ordinal to 0 so it never goes past WIDTH-1.
          r_state <= S_IDLE;
          r_seq   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_empty <= 1'b0;
        end else begin
          r_seq <= r_seq + c_seq_one;
        end
      end
      if (w_in_fire) begin
        r_state    <= S_EMIT;
        r_residual <= bus.in_data;
        r_seq      <= '0;
        r_valid    <= 1'b1;
        r_busy     <= 1'b1;
        r_empty    <= (bus.in_data == '0);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_index = w_index;
  assign bus.out_last  = w_last;
  assign bus.out_empty = r_empty;
  assign bus.out_seq   = r_seq;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bit_index_enumerator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_index_enumerator
//  Description : Self-checking bench for bit_index_enumerator. It uses a
//                beat scoreboard, a table of words and short directed
//                corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_index_enumerator;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  bit_index_enumerator_if #(.WIDTH(WIDTH)) bus();

  bit_index_enumerator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit empty;
    int seq;
  } beat_t;

  typedef struct {
    logic [31:0] word;
    int          beats;
    int          first;
  } vec_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    n_beats = 0;
  int    first_idx = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expand a word into its expected beat list.
  function automatic void push_word(input logic [31:0] w);
    int cnt;
    int s;
    cnt = $countones(w);
    s = 0;
    if (w == 32'h0) begin
      q.push_back('{idx: 0, last: 1'b1, empty: 1'b1, seq: 0});
    end else begin
      for (int i = 31; i >= 0; i--) begin
        if (w[i]) begin
          q.push_back('{idx: i, last: (s == cnt - 1), empty: 1'b0, seq: s});
          s++;
        end
      end
    end
  endfunction

  // Monitor: every output handshake is compared against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got index %0d expected no beat at %0t",
                 bus.out_index, $time);
      end else begin
        e = q.pop_front();
        chk("beat_index", int'(bus.out_index), e.idx);
        chk("beat_last",  int'(bus.out_last),  int'(e.last));
        chk("beat_empty", int'(bus.out_empty), int'(e.empty));
        chk("beat_seq",   int'(bus.out_seq),   e.seq);
      end
      if (n_beats == 0) first_idx = int'(bus.out_index);
      n_beats++;
    end
  end

  // Present a word and hold it until accepted. The task is entered and
  // left at 1 time unit after a rising edge.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_word(w);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
    end
  endtask

  // Wait until every expected beat has drained and the block is idle.
  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.out_valid && q.size() == 0) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
    chk("idle_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{word: 32'h8080_8100, beats: 4,  first: 31};
    vecs[1] = '{word: 32'h0000_0000, beats: 1,  first: 0};
    vecs[2] = '{word: 32'h0000_0001, beats: 1,  first: 0};
    vecs[3] = '{word: 32'hA5A5_A5A5, beats: 16, first: 31};
    vecs[4] = '{word: 32'h0001_0000, beats: 1,  first: 16};
    vecs[5] = '{word: 32'hFFFF_FFFF, beats: 32, first: 31};
    vecs[6] = '{word: 32'h4000_0002, beats: 2,  first: 30};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready",  int'(bus.in_ready),  0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_out_index", int'(bus.out_index), 0);
    chk("rst_out_last",  int'(bus.out_last),  0);
    chk("rst_out_empty", int'(bus.out_empty), 0);
    chk("rst_out_seq",   int'(bus.out_seq),   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table of words with free-running consumer.
    for (int v = 0; v < 7; v++) begin
      n_beats   = 0;
      first_idx = -1;
      send_word(vecs[v].word);
      @(negedge clk);
      chk("first_beat_latency", int'(bus.out_valid), 1);
      wait_idle();
      chk("tbl_beat_count", n_beats, vecs[v].beats);
      chk("tbl_first_index", first_idx, vecs[v].first);
      chk("tbl_out_valid_after", int'(bus.out_valid), 0);
    end

    // All-ones followed directly by 0x1: no bubble between words.
    n_beats = 0;
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0001);
    @(negedge clk);
    chk("b2b_valid", int'(bus.out_valid), 1);
    chk("b2b_index", int'(bus.out_index), 0);
    chk("b2b_seq",   int'(bus.out_seq),   0);
    chk("b2b_last",  int'(bus.out_last),  1);
    wait_idle();
    chk("b2b_beat_count", n_beats, 33);

    // Backpressure: first beat held for 5 cycles.
    n_beats = 0;
    bus.out_ready = 1'b0;
    send_word(32'h0000_0012);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid",    int'(bus.out_valid), 1);
      chk("bp_index",    int'(bus.out_index), 4);
      chk("bp_seq",      int'(bus.out_seq),   0);
      chk("bp_in_ready", int'(bus.in_ready),  0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_idle();
    chk("bp_beat_count", n_beats, 2);

    // Reset after the first beat of 0x8000_0001 is taken.
    send_word(32'h8000_0001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy",  int'(bus.busy),      0);
    chk("mid_rst_seq",   int'(bus.out_seq),   0);
    @(posedge clk);
    #1;
    n_beats   = 0;
    first_idx = -1;
    send_word(32'h0000_0004);
    wait_idle();
    chk("post_rst_count", n_beats, 1);
    chk("post_rst_index", first_idx, 2);

    // A word held while busy waits for the prior word's last handshake.
    n_beats = 0;
    send_word(32'h0000_0300);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0003;
    @(negedge clk);
    chk("hold_in_ready_busy", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_in_ready_last", int'(bus.in_ready), 1);
    push_word(32'h0000_0003);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();
    chk("hold_beat_count", n_beats, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_index_enumerator.md
# bit_index_enumerator

Streaming decoder that turns a WIDTH-bit word into the ordered list of positions of its set bits, one index per output beat. It is the inverse of building a word from an index-keyed pattern such as {31:1, 23:1, 15:1, 8:1, default:0}. Here the word arrives on a valid/ready input, and the indices 31, 23, 15, 8 leave on a valid/ready output, highest first. It sits between any producer of sparse bit masks (request vectors, enable maps) and a consumer that services one index at a time.

## Interface

- WIDTH, 32, input word width; must be ≥ 2.
- IDXW, $clog2(WIDTH), index width; derived, do not override.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to enumerate.
- out_valid  output  1  out_index, out_last, out_empty and out_seq are valid.
- out_ready  input  1  consumer takes the current beat.
- out_index  output  IDXW  bit position of the current set bit.
- out_last  output  1  current beat is the final beat for this word.
- out_empty  output  1  the word had no set bits; this beat carries no index.
- out_seq  output  IDXW+1  ordinal of the beat within its word, starting at 0.
- busy  output  1  a word is held and not yet fully emitted.

## Operation

- Reset values, all applied while rst_n is low at a clock edge:
  - state = IDLE, residual = 0, out_seq = 0.
  - out_valid = 0, out_index = 0, out_last = 0, out_empty = 0, busy = 0, in_ready = 0.
- in_ready is 0 while rst_n is low; after reset it equals (state == IDLE) || (out_valid && out_ready && out_last).
- Input accept: when in_valid && in_ready, the word is captured into the residual register and the state moves to EMIT. out_seq resets to 0. A zero word sets the empty flag.
- States:
  - IDLE: no word held; out_valid = 0.
  - EMIT: out_valid = 1; busy = 1.
- Beat contents in EMIT:
  - out_index = position of the highest set bit of residual.
  - out_last = 1 when residual has exactly one set bit.
  - For an empty word: out_empty = 1, out_index = 0, out_last = 1. This is exactly one beat.
- Output handshake (out_valid && out_ready):
  - The emitted bit is cleared from residual and out_seq increments.
  - If out_last is set: go to IDLE, unless a new word is accepted in the same cycle, in which case stay in EMIT with the new word.
- Backpressure: while out_valid && !out_ready, all out_* signals and the residual register hold unchanged.
- in_data is ignored while in_ready = 0. The producer must hold the word, per standard valid/ready rules.
- Reset mid-operation discards the residual word and any pending beats; no partial beat is emitted afterwards.
- out_index comes from a combinational priority encode of the registered residual. The output has no combinational path from in_* or out_ready to out_valid, out_index or out_last.

## Timing

- Latency: a word accepted at edge N gives its first beat valid from N+1.
- Throughput: one index per cycle while out_ready = 1. A word with k set bits takes max(k,1) beats.
- Back-to-back words: the next word is accepted in the same cycle as the last beat's handshake, so its first beat appears the following cycle. There is no bubble.
- in_ready depends combinationally on out_ready (last-beat pass-through). Document this for integration; it is not registered.
- out_seq never exceeds WIDTH-1. The all-ones word ends with out_seq = WIDTH-1 and index 0.

## Test plan

- in_data 0x8080_8100, out_ready = 1 -> beats index 31, 23, 15, 8 on consecutive cycles; out_seq 0..3; out_last only on index 8; out_empty = 0 throughout.
- in_data 0x0000_0000 -> exactly one beat with out_empty = 1, out_last = 1, out_index = 0, out_seq = 0; then out_valid = 0 and busy = 0.
- in_data 0xFFFF_FFFF followed immediately by 0x0000_0001, out_ready = 1 -> 32 beats with index 31 down to 0 over 32 cycles. The second word is accepted on the cycle of index 0. The next cycle shows index 0 with last = 1 and seq = 0, with no idle gap.
- in_data 0x0000_0012, out_ready low for 5 cycles after the first beat -> index 4 (seq 0) held stable for all 5 cycles and in_ready = 0 throughout; on release, index 4 then index 1 with last = 1.
- in_data 0x8000_0001, rst_n driven low for one cycle after the first beat (index 31) is taken -> next cycle out_valid = 0, busy = 0, out_seq = 0. Index 0 is never emitted. A fresh word 0x0000_0004 afterwards yields index 2 with last = 1.
- in_valid held with word 0x0000_0003 while busy on a prior word -> in_ready stays 0 until the prior word's last-beat handshake; then it is accepted and produces indices 1 and 0.
